pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/pipelined_barrel_shifter_if.sv | 27 ++
 rtl/pipelined_barrel_shifter.sv | 117 +++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Upstream/downstream valid-ready bundle for pipelined_barrel_shifter.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned SW = $clog2(N);

  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shamt;
  logic [1:0]    up_mode;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;

  // Producer of operands / consumer of results.
  modport master (
    output up_valid, up_data, up_shamt, up_mode, down_ready,
    input  up_ready, down_valid, down_data
  );

  // The shifter itself.
  modport slave (
    input  up_valid, up_data, up_shamt, up_mode, down_ready,
    output up_ready, down_valid, down_data
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// SW-stage pipelined barrel shifter (LSL / LSR / ASR / ROR) with
// valid-ready handshake and bubble-collapsing stage loads.
module pipelined_barrel_shifter #(
  parameter int unsigned N = 8
) (
  input logic                     clk,
  input logic                     rst,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int unsigned SW = $clog2(N);

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int unsigned SH = 1 << k;
    // Bits vacated by a right shift of SH; filled with the sign for ASR.
    localparam logic [N-1:0] FILL_MASK = ~({N{1'b1}} >> SH);

    logic          in_v;
    logic [N-1:0]  in_d;
    logic [SW-1:0] in_s;
    mode_e         in_m;
    logic          load;
    logic [N-1:0]  shifted;

    logic          valid_q, valid_d;
    logic [N-1:0]  data_q, data_d;
    logic [SW-1:0] shamt_q, shamt_d;
    mode_e         mode_q, mode_d;

    if (k == 0) begin : g_src
      // Stage 0 is fed straight from the upstream port.
      always_comb begin
        in_v = bus.up_valid;
        in_d = bus.up_data;
        in_s = bus.up_shamt;
        in_m = mode_e'(bus.up_mode);
      end
    end else begin : g_src
      // Later stages are fed from the previous stage register.
      always_comb begin
        in_v = g_stage[k-1].valid_q;
        in_d = g_stage[k-1].data_q;
        in_s = g_stage[k-1].shamt_q;
        in_m = g_stage[k-1].mode_q;
      end
    end

    if (k == SW - 1) begin : g_load
      // Last stage advances when empty or the consumer takes the result.
      always_comb load = ~valid_q | bus.down_ready;

      logic unused_tail;
      // Shamt and mode reach the last register but nothing reads them there.
      always_comb unused_tail = ^{shamt_q, mode_q};
    end else begin : g_load
      // Inner stage advances when empty or the next stage loads.
      always_comb load = ~valid_q | g_stage[k+1].load;
    end

    // Conditional shift by 2^k; ASR keeps using bit N-1, which earlier
    // ASR stages preserve, so it always equals the original sign bit.
    always_comb begin
      shifted = in_d;
      if (in_s[k]) begin
        unique case (in_m)
          MODE_LSL: shifted = in_d << SH;
          MODE_LSR: shifted = in_d >> SH;
          MODE_ASR: shifted = (in_d >> SH) | (in_d[N-1] ? FILL_MASK : '0);
          MODE_ROR: shifted = (in_d >> SH) | (in_d << (N - SH));
          default:  shifted = in_d;
        endcase
      end
    end

    // Stage register next state: capture on load, otherwise hold.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      shamt_d = shamt_q;
      mode_d  = mode_q;
      if (load) begin
        valid_d = in_v;
        data_d  = shifted;
        shamt_d = in_s;
        mode_d  = in_m;
      end
    end

    // Stage register with synchronous clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        shamt_q <= '0;
        mode_q  <= MODE_LSL;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        shamt_q <= shamt_d;
        mode_q  <= mode_d;
      end
    end
  end

  // Handshake outputs; down_data comes straight from the last register.
  always_comb begin
    bus.up_ready   = ~rst & g_stage[0].load;
    bus.down_valid = g_stage[SW-1].valid_q;
    bus.down_data  = g_stage[SW-1].data_q;
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (N = 8).
module tb_pipelined_barrel_shifter;
  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.N(N)) bus ();
  pipelined_barrel_shifter #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic         s_ur, s_dv, s_uf, s_df;
  logic [N-1:0] s_dd;

  // Reference: bit-by-bit definition of each shift mode.
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int unsigned s,
                                             input logic [1:0] m);
    logic [N-1:0] r;
    for (int unsigned i = 0; i < N; i++) begin
      case (m)
        2'b00:   r[i] = (i >= s) ? d[i-s] : 1'b0;
        2'b01:   r[i] = (i + s < N) ? d[i+s] : 1'b0;
        2'b10:   r[i] = (i + s < N) ? d[i+s] : d[N-1];
        default: r[i] = d[(i+s) % N];
      endcase
    end
    return r;
  endfunction

  // One clock: inputs already driven; sample at negedge, return 1 after posedge.
  task automatic step();
    @(negedge clk);
    s_ur = bus.up_ready;
    s_dv = bus.down_valid;
    s_dd = bus.down_data;
    s_uf = bus.up_valid & s_ur;
    s_df = s_dv & bus.down_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] d, input logic [SW-1:0] s,
                       input logic [1:0] m);
    bus.up_valid = v;
    bus.up_data  = d;
    bus.up_shamt = s;
    bus.up_mode  = m;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 2'b00);
    bus.down_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 2'b00);
    bus.down_ready = 1'b1;
    step();
    step();
    n_cmp++; if (s_ur !== 1'b0) begin n_bad++; $display("FAIL reset_up_ready got=%b exp=0", s_ur); end
    n_cmp++; if (s_dv !== 1'b0) begin n_bad++; $display("FAIL reset_down_valid got=%b exp=0", s_dv); end
    n_cmp++; if (s_dd !== 8'h00) begin n_bad++; $display("FAIL reset_down_data got=%h exp=00", s_dd); end
    rst = 1'b0;
    step();
    n_cmp++; if (s_ur !== 1'b1) begin n_bad++; $display("FAIL post_reset_up_ready got=%b exp=1", s_ur); end
    n_cmp++; if (s_dv !== 1'b0) begin n_bad++; $display("FAIL post_reset_down_valid got=%b exp=0", s_dv); end
  endtask

  task automatic test_lsl_latency();
    int lat;
    logic [N-1:0] got;
    lat = -1;
    got = '0;
    bus.down_ready = 1'b1;
    drive(1'b1, 8'b10110011, 3'd3, 2'b00);
    step();
    n_cmp++; if (s_uf !== 1'b1) begin n_bad++; $display("FAIL lsl_accept got=%b exp=1", s_uf); end
    drive(1'b0, '0, '0, 2'b00);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (s_dv === 1'b1 && lat < 0) begin lat = c; got = s_dd; end
    end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL lsl_latency got=%0d exp=3", lat); end
    n_cmp++; if (got !== 8'b10011000) begin n_bad++; $display("FAIL lsl_data got=%b exp=10011000", got); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_d [3];
    logic [N-1:0] got_d [$];
    int           got_c [$];
    exp_d[0] = 8'b00010110; exp_d[1] = 8'b11110110; exp_d[2] = 8'b01110110;
    bus.down_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 3) drive(1'b1, 8'b10110011, 3'd3, 2'(c + 1));
      else       drive(1'b0, '0, '0, 2'b00);
      step();
      if (c < 3) begin
        n_cmp++; if (s_uf !== 1'b1) begin n_bad++; $display("FAIL b2b_accept%0d got=%b exp=1", c, s_uf); end
      end
      if (s_df) begin got_d.push_back(s_dd); got_c.push_back(c); end
    end
    n_cmp++;
    if (got_d.size() != 3) begin
      n_bad++; $display("FAIL b2b_count got=%0d exp=3", got_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got_d[i] !== exp_d[i]) begin n_bad++; $display("FAIL b2b_data%0d got=%b exp=%b", i, got_d[i], exp_d[i]); end
        n_cmp++;
        if (got_c[i] != 3 + i) begin n_bad++; $display("FAIL b2b_cycle%0d got=%0d exp=%0d", i, got_c[i], 3 + i); end
      end
    end
  endtask

  task automatic test_shamt_zero();
    logic [N-1:0] got_d [$];
    bus.down_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive(1'b1, 8'b01011010, 3'd0, 2'(c));
      else       drive(1'b0, '0, '0, 2'b00);
      step();
      if (s_df) got_d.push_back(s_dd);
    end
    n_cmp++;
    if (got_d.size() != 4) begin
      n_bad++; $display("FAIL shamt0_count got=%0d exp=4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_d[i] !== 8'b01011010) begin n_bad++; $display("FAIL shamt0_mode%0d got=%b exp=01011010", i, got_d[i]); end
      end
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] ops [5];
    logic [N-1:0] got_d [$];
    int idx;
    ops[0] = 8'h11; ops[1] = 8'h22; ops[2] = 8'h33; ops[3] = 8'h44; ops[4] = 8'h55;
    idx = 0;
    bus.down_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, ops[idx < 5 ? idx : 0], 3'd0, 2'b00);
      step();
      if (s_uf) idx++;
      if (s_dv) begin
        n_cmp++;
        if (s_dd !== ops[0]) begin n_bad++; $display("FAIL stall_hold c%0d got=%h exp=%h", c, s_dd, ops[0]); end
      end
    end
    n_cmp++; if (idx != 3) begin n_bad++; $display("FAIL stall_accepted got=%0d exp=3", idx); end
    n_cmp++; if (s_ur !== 1'b0) begin n_bad++; $display("FAIL stall_up_ready got=%b exp=0", s_ur); end
    bus.down_ready = 1'b1;
    for (int c = 0; c < 30 && got_d.size() < 5; c++) begin
      drive(idx < 5, ops[idx < 5 ? idx : 0], 3'd0, 2'b00);
      step();
      if (s_uf) idx++;
      if (s_df) got_d.push_back(s_dd);
    end
    n_cmp++;
    if (got_d.size() != 5) begin
      n_bad++; $display("FAIL stall_out_count got=%0d exp=5", got_d.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (got_d[i] !== ops[i]) begin n_bad++; $display("FAIL stall_order%0d got=%h exp=%h", i, got_d[i], ops[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int leaked;
    leaked = 0;
    bus.down_ready = 1'b1;
    drive(1'b1, 8'hAA, 3'd1, 2'b00);
    step();
    drive(1'b1, 8'hBB, 3'd2, 2'b01);
    step();
    drive(1'b0, '0, '0, 2'b00);
    rst = 1'b1;
    step();
    n_cmp++; if (s_ur !== 1'b0) begin n_bad++; $display("FAIL midrst_up_ready_in_reset got=%b exp=0", s_ur); end
    rst = 1'b0;
    step();
    n_cmp++; if (s_dv !== 1'b0) begin n_bad++; $display("FAIL midrst_down_valid got=%b exp=0", s_dv); end
    n_cmp++; if (s_ur !== 1'b1) begin n_bad++; $display("FAIL midrst_up_ready got=%b exp=1", s_ur); end
    for (int c = 0; c < 8; c++) begin
      step();
      if (s_dv) leaked++;
    end
    n_cmp++; if (leaked != 0) begin n_bad++; $display("FAIL midrst_leaked got=%0d exp=0", leaked); end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_q [$];
    logic [N-1:0] cur_d, e;
    logic [SW-1:0] cur_s;
    logic [1:0]   cur_m;
    int sent, recv;
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      cur_d = N'($urandom);
      cur_s = SW'($urandom_range(0, N - 1));
      cur_m = 2'($urandom_range(0, 3));
      drive(sent < 1000 && $urandom_range(0, 3) != 0, cur_d, cur_s, cur_m);
      bus.down_ready = ($urandom_range(0, 3) != 0);
      step();
      if (s_uf) begin
        exp_q.push_back(ref_shift(cur_d, int'(cur_s), cur_m));
        sent++;
      end
      if (s_df) begin
        recv++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rand_extra got=%h exp=none", s_dd);
        end else begin
          e = exp_q.pop_front();
          if (s_dd !== e) begin n_bad++; $display("FAIL rand_data#%0d got=%h exp=%h", recv, s_dd, e); end
        end
      end
    end
    n_cmp++; if (recv != 1000) begin n_bad++; $display("FAIL rand_count got=%0d exp=1000", recv); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_pending got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 2'b00);
    bus.down_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_lsl_latency();
    drain();
    test_back_to_back();
    drain();
    test_shamt_zero();
    drain();
    test_stall();
    drain();
    test_reset_mid();
    drain();
    test_random();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
